// File: rtl/rf_gearbox_pkg.sv
// rf_gearbox_pkg: shared limits, phase-width helper and I/Q packing order for the ADC gearboxes
package rf_gearbox_pkg;
    localparam int MAX_SPC = 16;
    localparam bit IQ_ORDER_QI = 1'b0;
    localparam bit IQ_ORDER_IQ = 1'b1;

    function automatic int phase_w(input int spc);
        return (spc > 1) ? $clog2(spc) : 1;
    endfunction
endpackage

// File: rtl/gearbox_word_buf.sv
// gearbox_word_buf: 2-entry word FIFO, head visible on dout, push accepted when not full or popping
module gearbox_word_buf #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         full
);
    logic [W-1:0] mem [2];
    logic rd_ptr, wr_ptr, do_pop, do_push;

    assign full    = count == 2'd2;
    assign do_pop  = pop && count != 2'd0;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/adc_gearbox_nx1.sv
// adc_gearbox_nx1: serialises NUM_SPC-sample I/Q words into one registered {Q,I} sample per cycle
module adc_gearbox_nx1
    import rf_gearbox_pkg::*;
#(
    parameter int  NUM_SPC  = 4,
    parameter int  SAMPLE_W = 16,
    localparam int PW       = phase_w(NUM_SPC)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_SPC*SAMPLE_W-1:0] adc_i_in,
    input  logic [NUM_SPC*SAMPLE_W-1:0] adc_q_in,
    input  logic                        valid_in,
    input  logic                        enable,
    input  logic                        swap_iq,
    output logic [2*SAMPLE_W-1:0]       adc_out,
    output logic                        valid_out,
    output logic                        last_out,
    output logic [PW-1:0]               phase_out,
    output logic                        overflow,
    output logic                        underflow
);
    localparam int WW = NUM_SPC * SAMPLE_W;

    logic [2*WW-1:0] head;
    logic [1:0] count;
    logic full, emit, pop, drop, started;
    logic [PW-1:0] phase;
    logic [NUM_SPC-1:0][SAMPLE_W-1:0] head_i, head_q;
    logic [2*SAMPLE_W-1:0] sample;

    gearbox_word_buf #(.W(2 * WW)) u_buf (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (!enable),
        .push   (valid_in && enable),
        .pop    (pop),
        .din    ({adc_q_in, adc_i_in}),
        .dout   (head),
        .count  (count),
        .full   (full)
    );

    assign head_i = head[WW-1:0];
    assign head_q = head[2*WW-1:WW];
    assign emit   = enable && count != 2'd0;
    assign pop    = emit && phase == PW'(NUM_SPC - 1);
    assign drop   = valid_in && enable && full && !pop;
    assign sample = (swap_iq == IQ_ORDER_IQ) ? {head_i[phase], head_q[phase]}
                                             : {head_q[phase], head_i[phase]};

    // NUM_SPC is a power of two, so the phase counter wraps on its own at the pop
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            phase     <= '0;
            started   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            valid_out <= 1'b0;
            adc_out   <= '0;
            phase_out <= '0;
            last_out  <= 1'b0;
        end else begin
            phase     <= phase + PW'(emit);
            started   <= started | emit;
            overflow  <= overflow | drop;
            underflow <= underflow | (started && count == 2'd0);
            valid_out <= emit;
            adc_out   <= emit ? sample : '0;
            phase_out <= emit ? phase : '0;
            last_out  <= pop;
        end
    end
endmodule

// File: tb/tb_adc_gearbox_nx1.sv
// tb_adc_gearbox_nx1: queue-based reference model feeding a scoreboard, plus directed boundary checks
module tb_adc_gearbox_nx1;
    localparam int N = 4;
    localparam int SW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, valid_in, enable, swap_iq;
    logic [N*SW-1:0] adc_i_in, adc_q_in;
    logic [2*SW-1:0] adc_out;
    logic valid_out, last_out, overflow, underflow;
    logic [1:0] phase_out;

    adc_gearbox_nx1 #(.NUM_SPC(N), .SAMPLE_W(SW)) dut (
        .clk(clk), .reset_n(reset_n), .adc_i_in(adc_i_in), .adc_q_in(adc_q_in),
        .valid_in(valid_in), .enable(enable), .swap_iq(swap_iq), .adc_out(adc_out),
        .valid_out(valid_out), .last_out(last_out), .phase_out(phase_out),
        .overflow(overflow), .underflow(underflow)
    );

    typedef struct packed {
        logic [2*SW-1:0] data;
        logic            last;
        logic [1:0]      ph;
    } exp_t;

    exp_t exp_q[$];
    logic [2*N*SW-1:0] mq[$];
    int mph;
    bit mstart, movf, munf;
    int vectors = 0, miscompares = 0, nvalid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Reference: list of accepted words, sample index into the head word, spec flag rules
    always @(posedge clk) begin : model
        bit em, pp;
        logic [2*N*SW-1:0] lw;
        logic [SW-1:0] qs, is;
        exp_t e;
        if (!reset_n || !enable) begin
            mq.delete();
            mph = 0; mstart = 0; movf = 0; munf = 0;
        end else begin
            em = mq.size() > 0;
            pp = em && mph == N - 1;
            if (!em && mstart) munf = 1;
            if (em) begin
                lw = mq[0];
                is = lw[mph*SW +: SW];
                qs = lw[N*SW + mph*SW +: SW];
                e.data = swap_iq ? {is, qs} : {qs, is};
                e.last = pp;
                e.ph = 2'(mph);
                exp_q.push_back(e);
                mstart = 1;
            end
            if (pp) begin
                void'(mq.pop_front());
                mph = 0;
            end else if (em) mph++;
            if (valid_in) begin
                if (mq.size() < 2) mq.push_back({adc_q_in, adc_i_in});
                else movf = 1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        chk("valid_out", valid_out, exp_q.size() != 0);
        if (valid_out) begin
            nvalid++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("adc_out", adc_out, e.data);
                chk("last_out", last_out, e.last);
                chk("phase_out", phase_out, e.ph);
            end
        end else begin
            chk("idle_zero", {adc_out, last_out, phase_out}, 0);
            exp_q.delete();
        end
        chk("overflow", overflow, movf);
        chk("underflow", underflow, munf);
    end

    task automatic step(input bit v, input logic [N*SW-1:0] wi, input logic [N*SW-1:0] wq);
        valid_in = v;
        adc_i_in = wi;
        adc_q_in = wq;
        @(negedge clk);
        #1;
    endtask

    task automatic flush();
        enable = 1'b0;
        step(0, '0, '0);
        chk("flush_clear", {valid_out, overflow, underflow, adc_out}, 0);
        enable = 1'b1;
    endtask

    function automatic logic [N*SW-1:0] rw();
        return {$urandom, $urandom};
    endfunction

    localparam logic [N*SW-1:0] WI = 64'h0003_0002_0001_0000;
    localparam logic [N*SW-1:0] WQ = 64'h0013_0012_0011_0010;

    initial begin
        reset_n = 0; enable = 1; swap_iq = 0; valid_in = 0; adc_i_in = '0; adc_q_in = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", {valid_out, adc_out, last_out, phase_out, overflow, underflow}, 0);
        reset_n = 1;

        step(1, WI, WQ);
        chk("t1_no_early_out", valid_out, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, '0, '0);
            chk("t1_data", adc_out, {16'(16'h10 + k), 16'(k)});
            chk("t1_phase", phase_out, k);
            chk("t1_last", last_out, k == 3);
        end
        step(0, '0, '0);
        chk("t1_underflow", underflow, 1);
        flush();

        swap_iq = 1;
        step(1, WI, WQ);
        step(0, '0, '0);
        chk("t2_swap", adc_out, 32'h0000_0010);
        repeat (4) step(0, '0, '0);
        swap_iq = 0;
        flush();

        nvalid = 0;
        for (int w = 0; w < 100; w++) begin
            step(1, rw(), rw());
            repeat (3) step(0, '0, '0);
        end
        step(0, '0, '0);
        chk("t3_contiguous", nvalid, 400);
        chk("t3_flags", {overflow, underflow}, 0);
        step(0, '0, '0);
        chk("t3_underflow_after", underflow, 1);
        flush();

        nvalid = 0;
        repeat (4) step(1, rw(), rw());
        repeat (10) step(0, '0, '0);
        chk("t4_two_words", nvalid, 8);
        chk("t4_overflow_sticky", overflow, 1);
        flush();

        nvalid = 0;
        for (int w = 0; w < 5; w++) begin
            step(1, rw(), rw());
            repeat (7) step(0, '0, '0);
        end
        chk("t5_words", nvalid, 20);
        chk("t5_underflow", underflow, 1);
        flush();

        step(1, rw(), rw());
        step(0, '0, '0);
        step(0, '0, '0);
        chk("t6_mid_phase", phase_out, 1);
        enable = 0;
        step(0, '0, '0);
        chk("t6_disable_out", {valid_out, adc_out, overflow, underflow}, 0);
        enable = 1;
        step(1, WI, WQ);
        step(0, '0, '0);
        chk("t6_restart", {valid_out, phase_out, adc_out}, {1'b1, 2'd0, 32'h0010_0000});
        repeat (4) step(0, '0, '0);

        step(1, rw(), rw());
        step(0, '0, '0);
        step(0, '0, '0);
        reset_n = 0;
        step(0, '0, '0);
        chk("t7_reset_out", {valid_out, adc_out, overflow, underflow}, 0);
        reset_n = 1;
        step(1, WI, WQ);
        step(0, '0, '0);
        chk("t7_restart", {valid_out, phase_out, adc_out}, {1'b1, 2'd0, 32'h0010_0000});
        repeat (4) step(0, '0, '0);

        for (int c = 0; c < 600; c++) begin
            swap_iq = 1'($urandom);
            enable = $urandom_range(0, 59) != 0;
            reset_n = $urandom_range(0, 149) != 0;
            step($urandom_range(0, 3) == 0, rw(), rw());
        end
        enable = 1; reset_n = 1;
        repeat (10) step(0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
